jk_bank_scheduler: RTL and testbench
====================================

# jk_bank_scheduler

Round-robin scheduler that shares a bank of JK flip-flop storage bits between several requesters. Each requester posts a JK command (hold/clear/set/toggle) for one bit index. The block grants at most one command per clock and applies it to the addressed bit with standard JK semantics. It sits between control agents and the flag/status bank built from the team's JK flip-flop cell, replacing ad-hoc direct drive of j/k inputs.

## Interface
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, number of JK bits in the bank (1..16)
- IDXW, 3, bit-index width per requester; must satisfy 2**IDXW >= NBITS
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester command request, level, held until granted
- op  input  2*NREQ  per-requester {j,k}; requester i uses op[2i+1:2i] (bit 1 = j, bit 0 = k)
- idx  input  IDXW*NREQ  per-requester target bit; requester i uses idx[IDXW*i +: IDXW]
- gnt  output  NREQ  one-hot grant pulse, registered, high one cycle
- q  output  NBITS  JK bank state
- q_bar  output  NBITS  always ~q
- err  output  1  registered pulse: the granted command had idx >= NBITS
- grant_cnt  output  8  count of grants issued, wraps 255 -> 0

## Operation
- Eligible set at each edge: req[i]=1 and gnt[i]=0. A requester is masked in the cycle its gnt is high. Requesters must drop req in that cycle or they are re-arbitrated on the following edge.
- Round-robin pointer ptr (0..NREQ-1). Winner is the first eligible index searching ptr, ptr+1, … modulo NREQ.
- On an edge with winner w:
  - gnt <= one-hot(w)
  - ptr <= (w+1) mod NREQ
  - grant_cnt <= grant_cnt+1
  - apply op_w to q[idx_w]: 00 hold, 01 clear to 0, 10 set to 1, 11 toggle
- On an edge with no eligible requester: gnt <= 0, err <= 0, ptr unchanged, q unchanged.
- Out of range (idx_w >= NBITS): grant still issued, pointer and count still advance, no q bit changes, err <= 1 for that one cycle.
- Only one bit changes per cycle. There are no write conflicts by construction.
- q_bar is combinational ~q and is never equal to q.
- Suggested structure: combinational masked round-robin priority encoder, a registered grant/pointer stage, and NBITS JK cells with j/k gated by decoded index. There is no other FSM. ptr is the only arbitration state.

## Timing
- Reset edge (reset=1): q=0, q_bar=all 1, gnt=0, err=0, grant_cnt=0, ptr=0. Requests present at the reset edge are ignored. Reset wins over any simultaneous request.
- Reset asserted mid-stream discards the in-flight arbitration result. The first grant after reset deasserts occurs at the first edge with reset=0.
- Latency: command sampled at edge E. gnt, q, err and grant_cnt all reflect it in the cycle after E (one-cycle latency, same edge).
- Throughput: 1 command per clock with ≥2 requesters active. A single requester is granted at most every other cycle, because of gnt masking.
- Fairness: with all NREQ requesters continuously requesting, each is granted exactly once in any NREQ consecutive grants.
- Pointer wrap: ptr = NREQ-1 winning sets ptr to 0.
- grant_cnt wrap: 255 + 1 = 0, with no flag.
- Outputs are glitch-free registered values, except q_bar, which is an inverter off registers.

## Test plan
- Reset: hold reset 2 cycles with req=4'b1111 -> q=8'h00, q_bar=8'hFF, gnt=0, grant_cnt=0 throughout; first grant one cycle after reset falls goes to requester 0.
- Single requester, JK truth table on bit 3 (ops 10, 11, 11, 01, 00, one per grant) -> after each grant q[3] = 1, 0, 1, 0, 0; gnt[0] pulses every other cycle while req held.
- All four requesting continuously (idx 0..3, op 11) -> gnt sequence 0001, 0010, 0100, 1000, 0001, …; bits 0..3 toggle once per 4 cycles; grant_cnt increases 1 per cycle.
- Pointer fairness: ptr=2 with req=4'b1011 -> grant to 3, then 0, then 1; requester 2 (not requesting) skipped.
- NBITS=6, idx=7, op 10 -> gnt pulse, err=1 for one cycle, q unchanged, grant_cnt+1.
- Assert reset for 1 cycle while two requests pending and q=8'hA5 -> q=0, gnt=0, ptr=0; after release, requester 0 granted first; 256 grants later grant_cnt returns to 0.

Source files
------------

// File: rtl/jk_bank_scheduler.sv
// Round-robin scheduler that grants one JK command per clock to a bank of JK bits.
// Masked round-robin priority encoder feeds a registered grant/pointer stage and NBITS JK cells.
module jk_bank_scheduler #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IDXW*NREQ-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NBITS-1:0]     q,
  output logic [NBITS-1:0]     q_bar,
  output logic                 err,
  output logic [7:0]           grant_cnt
);
  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTRW-1:0]  r_ptr;
  logic [NREQ-1:0]  r_gnt;
  logic [NBITS-1:0] r_q;
  logic             r_err;
  logic [7:0]       r_cnt;

  logic [NREQ-1:0]  w_elig;
  logic             w_found;
  logic [PTRW-1:0]  w_win;
  logic [1:0]       w_win_op;
  logic [IDXW-1:0]  w_win_idx;
  logic             w_oor;
  logic [NREQ-1:0]  w_gnt_next;
  logic [PTRW-1:0]  w_ptr_next;
  logic [NBITS-1:0] w_j;
  logic [NBITS-1:0] w_k;
  logic [NBITS-1:0] w_q_next;

  // A requester granted last cycle sits out this arbitration.
  assign w_elig = req & ~r_gnt;

  // Scan from the farthest offset down so the closest eligible index to r_ptr wins.
  always_comb begin
    int c;
    c       = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = (int'(r_ptr) + k) % NREQ;
      if (w_elig[c]) begin
        w_found = 1'b1;
        w_win   = PTRW'(c);
      end
    end
  end

  assign w_win_op   = op[2*w_win +: 2];
  assign w_win_idx  = idx[IDXW*w_win +: IDXW];
  assign w_oor      = (int'(w_win_idx) >= NBITS);
  assign w_ptr_next = (w_win == PTRW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NBITS; gi++) begin : g_jk
      logic w_sel;
      // Out-of-range indices match no cell, so the bank simply holds.
      assign w_sel       = w_found && (w_win_idx == IDXW'(gi));
      assign w_j[gi]     = w_sel & w_win_op[1];
      assign w_k[gi]     = w_sel & w_win_op[0];
      assign w_q_next[gi] = (w_j[gi] & ~r_q[gi]) | (~w_k[gi] & r_q[gi]);
    end
    for (gi = 0; gi < NREQ; gi++) begin : g_gnt
      assign w_gnt_next[gi] = w_found && (w_win == PTRW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      r_gnt <= '0;
      r_q   <= '0;
      r_err <= 1'b0;
      r_cnt <= 8'd0;
    end else begin
      r_gnt <= w_gnt_next;
      r_err <= w_found & w_oor;
      r_q   <= w_q_next;
      if (w_found) begin
        r_ptr <= w_ptr_next;
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign gnt       = r_gnt;
  assign q         = r_q;
  assign q_bar     = ~r_q;
  assign err       = r_err;
  assign grant_cnt = r_cnt;

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Scoreboard bench for jk_bank_scheduler (NREQ=4, NBITS=6 so out-of-range indices are reachable).
// Stimulus pushes expected grant results; a negedge monitor pops them whenever gnt is nonzero.
module tb_jk_bank_scheduler;
  localparam int NREQ  = 4;
  localparam int NBITS = 6;
  localparam int IDXW  = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [2*NREQ-1:0]    op;
  logic [IDXW*NREQ-1:0] idx;
  logic [NREQ-1:0]      gnt;
  logic [NBITS-1:0]     q;
  logic [NBITS-1:0]     q_bar;
  logic                 err;
  logic [7:0]           grant_cnt;

  always #5 clk = ~clk;

  jk_bank_scheduler #(.NREQ(NREQ), .NBITS(NBITS), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .idx(idx),
    .gnt(gnt), .q(q), .q_bar(q_bar), .err(err), .grant_cnt(grant_cnt)
  );

  typedef struct packed {
    logic [NREQ-1:0]  g;
    logic [NBITS-1:0] q;
    logic             e;
    logic [7:0]       c;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  logic [NBITS-1:0] m_q;
  logic [7:0]       m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [IDXW-1:0] x);
    op[2*i +: 2]       = o;
    idx[IDXW*i +: IDXW] = x;
  endtask

  // Expected outcome of one grant: winner g applying op o to bit x.
  task automatic push(input logic [NREQ-1:0] g, input logic [1:0] o, input int x);
    exp_t e;
    m_cnt = m_cnt + 8'd1;
    if (x < NBITS) begin
      case (o)
        2'b01:   m_q[x] = 1'b0;
        2'b10:   m_q[x] = 1'b1;
        2'b11:   m_q[x] = ~m_q[x];
        default: ;
      endcase
    end
    e.g = g;
    e.q = m_q;
    e.e = (x >= NBITS);
    e.c = m_cnt;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [NBITS-1:0] eqb;
    if (gnt != '0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_grant: got gnt=%b expected no grant", gnt);
      end else begin
        e   = sb.pop_front();
        eqb = ~e.q;
        chk("gnt", 32'(gnt), 32'(e.g));
        chk("q", 32'(q), 32'(e.q));
        chk("q_bar", 32'(q_bar), 32'(eqb));
        chk("err", 32'(err), 32'(e.e));
        chk("grant_cnt", 32'(grant_cnt), 32'(e.c));
        $display("grant gnt=%b q=%h err=%b cnt=%0d", gnt, q, err, grant_cnt);
      end
    end
  end

  logic [1:0] tt_op [5] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
  logic       tt_q3 [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    reset = 1'b1;
    req   = '1;
    op    = '0;
    idx   = '0;
    m_q   = '0;
    m_cnt = 8'd0;

    // Reset held two cycles with all requesting
    for (int n = 0; n < 2; n++) begin
      cyc();
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_q_bar", 32'(q_bar), 32'h3F);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_cnt", 32'(grant_cnt), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
    end
    reset = 1'b0;
    push(4'b0001, 2'b00, 0);
    cyc();
    req = '0;
    cyc();
    chk("idle_gnt", 32'(gnt), 32'h0);

    // JK truth table on bit 3 from requester 0 (ptr=1)
    req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      set_req(0, tt_op[k], 3'd3);
      push(4'b0001, tt_op[k], 3);
      cyc();
      chk("tt_q3", 32'(q[3]), 32'(tt_q3[k]));
      cyc();
      chk("tt_mask", 32'(gnt), 32'h0);
    end
    req = '0;
    cyc();

    // All four toggling bits 0..3 (ptr=1)
    for (int i = 0; i < 4; i++) set_req(i, 2'b11, IDXW'(i));
    req = 4'b1111;
    for (int n = 0; n < 8; n++) push(4'b0001 << ((n + 1) % 4), 2'b11, (n + 1) % 4);
    for (int n = 0; n < 8; n++) begin
      cyc();
      if (n == 3) chk("rr_q_half", 32'(q), 32'h0F);
    end
    req = '0;
    cyc();
    chk("rr_q_end", 32'(q), 32'h00);

    // Fairness: move ptr to 2, then req=1011 -> 3, 0, 1
    set_req(1, 2'b00, 3'd0);
    req = 4'b0010;
    push(4'b0010, 2'b00, 0);
    cyc();
    req = 4'b1011;
    set_req(3, 2'b10, 3'd5);
    set_req(0, 2'b10, 3'd4);
    set_req(1, 2'b01, 3'd4);
    push(4'b1000, 2'b10, 5);
    push(4'b0001, 2'b10, 4);
    push(4'b0010, 2'b01, 4);
    repeat (3) cyc();
    req = '0;
    cyc();

    // Out-of-range indices 7 and 6 (ptr=2)
    set_req(2, 2'b10, 3'd7);
    set_req(3, 2'b11, 3'd6);
    req = 4'b1100;
    push(4'b0100, 2'b10, 7);
    push(4'b1000, 2'b11, 6);
    cyc();
    cyc();
    req = '0;
    cyc();
    chk("oor_err_clear", 32'(err), 32'h0);
    chk("oor_q", 32'(q), 32'h20);

    // Load q=0x25, then reset mid-stream with requests pending
    set_req(0, 2'b10, 3'd0);
    set_req(1, 2'b10, 3'd2);
    req = 4'b0011;
    push(4'b0001, 2'b10, 0);
    push(4'b0010, 2'b10, 2);
    cyc();
    cyc();
    chk("load_q", 32'(q), 32'h25);
    reset = 1'b1;
    req   = 4'b0101;
    set_req(0, 2'b00, 3'd0);
    set_req(2, 2'b00, 3'd0);
    cyc();
    chk("rst2_q", 32'(q), 32'h0);
    chk("rst2_q_bar", 32'(q_bar), 32'h3F);
    chk("rst2_gnt", 32'(gnt), 32'h0);
    chk("rst2_cnt", 32'(grant_cnt), 32'h0);
    m_q   = '0;
    m_cnt = 8'd0;
    reset = 1'b0;
    for (int n = 0; n < 256; n++) push((n % 2 == 0) ? 4'b0001 : 4'b0100, 2'b00, 0);
    for (int n = 0; n < 256; n++) cyc();
    chk("cnt_wrap", 32'(grant_cnt), 32'h0);
    req = '0;
    repeat (4) cyc();
    chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
